// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hzState_t;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for a 5-stage pipeline, with a data-memory
// wait FSM, a sticky wait timeout and saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FORWARD_EN  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              BranchTakenE,
  input  logic              MemAccessM,
  input  logic              mem_ready,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              mem_timeout
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hzState_t          state;
  logic [WAIT_W-1:0] waitCnt;
  logic              memStall;
  logic              loadUse;
  logic              rawStall;
  logic              dataStall;
  logic              branchFlush;

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs)) return FWD_M;
    if (RegWriteW && (RdW != '0) && (RdW == rs)) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic rawHit(input logic [REG_AW-1:0] rs);
    return (rs != '0) && ((RegWriteE && (rs == RdE)) || (RegWriteM && (rs == RdM)));
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    ForwardAE   = FWD_RF;
    ForwardBE   = FWD_RF;
    branchFlush = 1'b0;

    memStall  = (state == MEM_WAIT) || (MemAccessM && !mem_ready);
    loadUse   = (ResultSrcE == RES_LOAD) && RegWriteE && (RdE != '0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    rawStall  = rawHit(Rs1D) || rawHit(Rs2D);
    dataStall = loadUse || ((FORWARD_EN == 0) && rawStall);

    // Priority: reset bubbles everything, then memory wait, then branch, then data hazard.
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (BranchTakenE) begin
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      branchFlush = 1'b1;
    end else if (dataStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end

    if (!rst && (FORWARD_EN != 0)) begin
      ForwardAE = fwdSel(Rs1E);
      ForwardBE = fwdSel(Rs2E);
    end
  end

  // A held BranchTakenE re-presents itself on the first RUN cycle, so the
  // deferred branch flush needs no extra state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MemAccessM && !mem_ready) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) state <= RUN;
          if (waitCnt != WAIT_MAX) waitCnt <= waitCnt + WAIT_W'(1);
          if (waitCnt == WAIT_LAST) mem_timeout <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branchFlush),
    .count (flush_cnt)
  );

endmodule
